// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI register bank:
//   - register address map (ADDR_EN_OUT_UO .. ADDR_DUTY)
//   - decoded SPI frame field bit positions
//   - FSM state type and state constants
// No ports (package).
// -----------------------------------------------------------------------------
package spi_reg_pkg;

   // Frame field layout: [15] write flag, [14:8] address, [7:0] data
   localparam int FRAME_WR_BIT   = 15;
   localparam int FRAME_ADDR_MSB = 14;
   localparam int FRAME_ADDR_LSB = 8;
   localparam int FRAME_DATA_MSB = 7;
   localparam int FRAME_DATA_LSB = 0;

   localparam int ADDR_W = FRAME_ADDR_MSB - FRAME_ADDR_LSB + 1;
   localparam int DATA_W = FRAME_DATA_MSB - FRAME_DATA_LSB + 1;

   // Register address map
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_UO  = 7'd0;
   localparam logic [ADDR_W-1:0] ADDR_EN_OUT_UIO = 7'd1;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_UO  = 7'd2;
   localparam logic [ADDR_W-1:0] ADDR_EN_PWM_UIO = 7'd3;
   localparam logic [ADDR_W-1:0] ADDR_DUTY       = 7'd4;

   // FSM state encoding
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_DECODE = 1'b1;

endpackage

// File: rtl/pwm_duty_shadow.sv
// -----------------------------------------------------------------------------
// pwm_duty_shadow
// Holds a duty-cycle write in a shadow register until the PWM block signals the
// end of a period, then commits it to the live duty output. This keeps a duty
// change from glitching a PWM period that is already in progress.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wr_en        : one-cycle strobe, a duty write is being decoded
//   wr_data[7:0] : value of that duty write
//   period_end   : one-cycle pulse at the last cycle of each PWM period
//   duty[7:0]    : committed duty cycle (registered)
//   pending      : a shadow value is waiting for the next period end (registered)
// -----------------------------------------------------------------------------
module pwm_duty_shadow
   import spi_reg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              period_end,
   output logic [DATA_W-1:0] duty,
   output logic              pending
);

   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] duty_q, duty_d;
   logic              pending_q, pending_d;
   logic              commit_s;

   // A commit only happens when something is actually waiting
   assign commit_s = period_end & pending_q;

   // Next-state: the commit always takes the shadow value from before this
   // cycle, so a write landing on the same edge stays pending for the next period
   always_comb begin
      duty_d    = duty_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (commit_s) begin
         duty_d = shadow_q;
      end else begin
         duty_d = duty_q;
      end
      if (wr_en) begin
         shadow_d  = wr_data;
         pending_d = 1'b1;
      end else if (commit_s) begin
         shadow_d  = shadow_q;
         pending_d = 1'b0;
      end else begin
         shadow_d  = shadow_q;
         pending_d = pending_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q  <= 8'h00;
         duty_q    <= 8'h00;
         pending_q <= 1'b0;
      end else begin
         shadow_q  <= shadow_d;
         duty_q    <= duty_d;
         pending_q <= pending_d;
      end
   end

   assign duty    = duty_q;
   assign pending = pending_q;

endmodule

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Register bank written by decoded SPI frames. A frame is captured in IDLE and
// decoded in the following DECODE cycle; writes to addresses 0..MAX_ADDR update
// the register at the end of DECODE, writes above MAX_ADDR bump a saturating
// error counter, read frames are accepted and dropped.
// Optional feature (macro DUTY_SHADOW_EN): the duty register (address 4) is
// double-buffered and only committed at a PWM period boundary.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   frame_valid           : one-cycle strobe, frame_data valid
//   frame_data[FRAME_W]   : [15] write, [14:8] address, [7:0] data
//   frame_ready           : frame can be accepted (FSM in IDLE)
//   pwm_period_end        : last cycle of a PWM period (used only with shadow)
//   en_out_uo .. pwm_duty_cycle : registers at addresses 0..4
//   duty_update_pending   : shadowed duty write waiting for a period end
//   err_count[ERR_W]      : saturating count of dropped write frames
// -----------------------------------------------------------------------------
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int FRAME_W  = 16,
   parameter int MAX_ADDR = 4,
   parameter int ERR_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_valid,
   input  logic [FRAME_W-1:0] frame_data,
   output logic               frame_ready,
   input  logic               pwm_period_end,
   output logic [7:0]         en_out_uo,
   output logic [7:0]         en_out_uio,
   output logic [7:0]         en_pwm_uo,
   output logic [7:0]         en_pwm_uio,
   output logic [7:0]         pwm_duty_cycle,
   output logic               duty_update_pending,
   output logic [ERR_W-1:0]   err_count
);

   localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);
   localparam logic [ERR_W-1:0]  ERR_MAX    = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0]  ERR_ONE    = ERR_W'(1);

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [7:0]         en_out_uo_q, en_out_uo_d;
   logic [7:0]         en_out_uio_q, en_out_uio_d;
   logic [7:0]         en_pwm_uo_q, en_pwm_uo_d;
   logic [7:0]         en_pwm_uio_q, en_pwm_uio_d;
   logic [ERR_W-1:0]   err_q, err_d;

   logic               wr_flag_s;
   logic [ADDR_W-1:0]  addr_s;
   logic [DATA_W-1:0]  data_s;
   logic               duty_wr_s;

   assign wr_flag_s = frame_q[FRAME_WR_BIT];
   assign addr_s    = frame_q[FRAME_ADDR_MSB:FRAME_ADDR_LSB];
   assign data_s    = frame_q[FRAME_DATA_MSB:FRAME_DATA_LSB];

   // FSM, frame capture and register write decode
   always_comb begin
      state_d      = state_q;
      frame_d      = frame_q;
      en_out_uo_d  = en_out_uo_q;
      en_out_uio_d = en_out_uio_q;
      en_pwm_uo_d  = en_pwm_uo_q;
      en_pwm_uio_d = en_pwm_uio_q;
      err_d        = err_q;
      duty_wr_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frame_valid) begin
               state_d = ST_DECODE;
               frame_d = frame_data;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: begin
            state_d = ST_IDLE;
            if (wr_flag_s && (addr_s <= MAX_ADDR_L)) begin
               case (addr_s)
                  ADDR_EN_OUT_UO:  en_out_uo_d  = data_s;
                  ADDR_EN_OUT_UIO: en_out_uio_d = data_s;
                  ADDR_EN_PWM_UO:  en_pwm_uo_d  = data_s;
                  ADDR_EN_PWM_UIO: en_pwm_uio_d = data_s;
                  ADDR_DUTY:       duty_wr_s    = 1'b1;
                  default:         duty_wr_s    = 1'b0;
               endcase
            end else if (wr_flag_s) begin
               // Out-of-range write: count it, but never wrap
               if (err_q != ERR_MAX) begin
                  err_d = err_q + ERR_ONE;
               end else begin
                  err_d = err_q;
               end
            end else begin
               // Read frames are accepted and dropped
               err_d = err_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset also drops a frame caught mid-decode
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         frame_q      <= {FRAME_W{1'b0}};
         en_out_uo_q  <= 8'h00;
         en_out_uio_q <= 8'h00;
         en_pwm_uo_q  <= 8'h00;
         en_pwm_uio_q <= 8'h00;
         err_q        <= {ERR_W{1'b0}};
      end else begin
         state_q      <= state_d;
         frame_q      <= frame_d;
         en_out_uo_q  <= en_out_uo_d;
         en_out_uio_q <= en_out_uio_d;
         en_pwm_uo_q  <= en_pwm_uo_d;
         en_pwm_uio_q <= en_pwm_uio_d;
         err_q        <= err_d;
      end
   end

`ifdef DUTY_SHADOW_EN
   pwm_duty_shadow u_duty_shadow (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (duty_wr_s),
      .wr_data    (data_s),
      .period_end (pwm_period_end),
      .duty       (pwm_duty_cycle),
      .pending    (duty_update_pending)
   );
`else
   logic [7:0] duty_q, duty_d;
   logic       unused_period_end_s;

   // Duty register written directly, like addresses 0..3
   always_comb begin
      if (duty_wr_s) begin
         duty_d = data_s;
      end else begin
         duty_d = duty_q;
      end
   end

   // Duty register
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q <= 8'h00;
      end else begin
         duty_q <= duty_d;
      end
   end

   assign pwm_duty_cycle      = duty_q;
   assign duty_update_pending = 1'b0;
   assign unused_period_end_s = pwm_period_end;
`endif

   assign frame_ready = (state_q == ST_IDLE);
   assign en_out_uo   = en_out_uo_q;
   assign en_out_uio  = en_out_uio_q;
   assign en_pwm_uo   = en_pwm_uo_q;
   assign en_pwm_uio  = en_pwm_uio_q;
   assign err_count   = err_q;

endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 The block SHALL take parameter FRAME_W, default 16, as the width of a decoded SPI frame.
REQ-002 The block SHALL take parameter MAX_ADDR, default 4, as the highest valid register address.
REQ-003 The block SHALL take parameter ERR_W, default 4, as the width of the error counter.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 frame_valid  input  1  one-cycle strobe from the SPI receiver: frame_data is valid.
REQ-007 frame_data  input  FRAME_W  [15] write flag (1=write), [14:8] address, [7:0] data.
REQ-008 frame_ready  output  1  high when a frame can be accepted.
REQ-009 pwm_period_end  input  1  one-cycle pulse from the PWM block at the last cycle of each PWM period.
REQ-010 en_out_uo, en_out_uio, en_pwm_uo, en_pwm_uio, pwm_duty_cycle  output  8 each  register values at addresses 0..4, driven to the PWM block.
REQ-011 duty_update_pending  output  1  a duty write is waiting for a period boundary.
REQ-012 err_count  output  ERR_W  count of dropped write frames.

Function
REQ-013 A frame SHALL be accepted on a rising edge where frame_valid=1 and frame_ready=1; a frame_valid with frame_ready=0 SHALL be discarded, with no retry.
REQ-014 The FSM SHALL have the states IDLE and DECODE, with IDLE->DECODE on accept and DECODE->IDLE unconditionally after one cycle.
REQ-015 frame_ready SHALL equal (state==IDLE), so it is low for exactly one cycle after each accept.
REQ-016 In DECODE, a write frame with address<=MAX_ADDR SHALL update the addressed register at the end of that cycle, making the new value visible 2 cycles after the accept edge.
REQ-017 A write frame with address>MAX_ADDR SHALL change no register and SHALL increment err_count.
REQ-018 err_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-019 A read frame (bit15=0) SHALL be accepted and dropped, with no register or counter change.
REQ-020 Address 4 SHALL follow the Configuration section.
REQ-021 Writes to addresses 0..3 SHALL always take effect immediately, as in REQ-016.

Reset
REQ-022 While rst=1, all register outputs, err_count, the shadow register and duty_update_pending SHALL be 0 and the state SHALL be IDLE.
REQ-023 While rst=1, frames SHALL be ignored.
REQ-024 rst asserted while in DECODE SHALL abort the pending write.

Configuration
REQ-025 With macro DUTY_SHADOW_EN defined, a write to address 4 SHALL load a shadow register and set duty_update_pending.
REQ-026 With DUTY_SHADOW_EN, on a cycle where pwm_period_end=1 and duty_update_pending=1, pwm_duty_cycle SHALL load the shadow value and pending SHALL clear.
REQ-027 With DUTY_SHADOW_EN, if a duty write and a commit fall in the same cycle, the commit SHALL use the prior shadow value, the shadow SHALL take the new value, and pending SHALL remain 1.
REQ-028 With DUTY_SHADOW_EN, a second duty write before a commit SHALL overwrite the shadow, with last write winning.
REQ-029 Without DUTY_SHADOW_EN, a write to address 4 SHALL update pwm_duty_cycle directly per REQ-016, duty_update_pending SHALL be tied to 0, and pwm_period_end SHALL be unused.

Structure
REQ-030 Package spi_reg_pkg SHALL hold the address constants (ADDR_EN_OUT_UO=0 .. ADDR_DUTY=4), the FSM state typedef and the frame field bit positions.
REQ-031 The shadow/commit logic SHALL be the single sub-module pwm_duty_shadow, instantiated only under DUTY_SHADOW_EN.

Verification
REQ-032 Write 0x80F0 (addr 0, data 0xF0) -> en_out_uo=0xF0 two cycles after accept; frame_ready low for exactly one cycle.
REQ-033 With DUTY_SHADOW_EN, write 0x8480 -> pwm_duty_cycle stays 0x00 and pending=1 until a pwm_period_end pulse, then 0x80 and pending=0.
REQ-034 With DUTY_SHADOW_EN, duty write 0x8440 then, during the DECODE of write 0x84C0, pulse pwm_period_end -> duty=0x40, then 0xC0 at the next pulse.
REQ-035 Send 17 writes to addr 0x10 -> err_count=15, all registers unchanged; read frame 0x0033 -> no change.
REQ-036 Back-to-back frame_valid on consecutive cycles -> second frame dropped; assert rst during DECODE -> all outputs 0 on the next cycle.
